// File: rtl/mem_data_buffer.sv
// mem_data_buffer: CPU bus buffer with a write-posting FIFO and a read register that waits for posted writes to drain.
module mem_data_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              bus_oe,
  input  logic              wr_push,
  output logic              wr_full,
  output logic              wr_empty,
  output logic              wr_overflow,
  input  logic              rd_start,
  input  logic              rd_byte,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [DATA_W-1:0] mem_wdata
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] fifo [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [DATA_W-1:0] rd_q;
  logic byte_q, push, pop, cap;
  assign wr_full = count == (AW+1)'(DEPTH);
  assign wr_empty = count == '0;
  // writes are held off the memory port while a read request is outstanding
  assign mem_wr_valid = !wr_empty && state != REQ;
  assign mem_wdata = fifo[rp];
  assign push = wr_push && !wr_full;
  assign pop = mem_wr_valid && mem_wr_ready;
  assign cap = state == REQ && mem_rd_ack;
  assign mem_rd_req = state == REQ;
  assign rd_busy = state != IDLE;
  assign bus = bus_oe ? rd_q : 'z;
  always_comb begin
    state_nx = state;
    if (state == IDLE && rd_start) state_nx = wr_empty ? REQ : DRAIN;
    else if (state == DRAIN && wr_empty) state_nx = REQ;
    else if (cap) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      wr_overflow <= 1'b0;
      state <= IDLE;
      rd_q <= '0;
      byte_q <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_push && wr_full) wr_overflow <= 1'b1;
      state <= state_nx;
      if (state == IDLE && rd_start) byte_q <= rd_byte;
      if (cap) rd_q <= byte_q ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
      rd_done <= cap;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= bus;
  end
endmodule

// File: tb/tb_mem_data_buffer.sv
// tb_mem_data_buffer: directed vectors with hand-computed expectations for mem_data_buffer.
module tb_mem_data_buffer;
  logic clk = 0, reset = 1;
  logic bus_oe = 0, wr_push = 0, rd_start = 0, rd_byte = 0;
  logic mem_rd_ack = 0, mem_wr_ready = 0;
  logic [15:0] mem_rdata = '0, bus_drv = '0;
  logic bus_en = 0;
  wire [15:0] bus;
  logic wr_full, wr_empty, wr_overflow, rd_busy, rd_done, mem_rd_req, mem_wr_valid;
  logic [15:0] mem_wdata;
  int cnt = 0, errs = 0;
  logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  assign bus = bus_en ? bus_drv : 'z;

  mem_data_buffer dut (
    .clk(clk), .reset(reset), .bus(bus), .bus_oe(bus_oe), .wr_push(wr_push),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_overflow(wr_overflow),
    .rd_start(rd_start), .rd_byte(rd_byte), .rd_busy(rd_busy), .rd_done(rd_done),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cnt++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    bus_drv = v;
    bus_en = 1;
    wr_push = 1;
    step();
    wr_push = 0;
    bus_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_empty", 16'(wr_empty), 16'd1);
    chk("rst_full", 16'(wr_full), 16'd0);
    chk("rst_ovf", 16'(wr_overflow), 16'd0);
    chk("rst_busy", 16'(rd_busy), 16'd0);
    chk("rst_req", 16'(mem_rd_req), 16'd0);
    chk("rst_wvalid", 16'(mem_wr_valid), 16'd0);
    chk("rst_done", 16'(rd_done), 16'd0);
    step();
    reset = 0;
    step();
    // fill, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      chk("fill_head", mem_wdata, 16'h1111);
    end
    chk("fill_full", 16'(wr_full), 16'd1);
    chk("fill_ovf0", 16'(wr_overflow), 16'd0);
    push(16'h5555);
    chk("ovf_set", 16'(wr_overflow), 16'd1);
    chk("ovf_full", 16'(wr_full), 16'd1);
    mem_wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 16'(mem_wr_valid), 16'd1);
      chk("drain_data", mem_wdata, vals[i]);
      step();
    end
    chk("drain_empty", 16'(wr_empty), 16'd1);
    chk("ovf_sticky", 16'(wr_overflow), 16'd1);
    // read with empty FIFO, ack on third request cycle
    rd_start = 1;
    step();
    rd_start = 0;
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("rd_req_hi", 16'(mem_rd_req), 16'd1);
      chk("rd_done_lo", 16'(rd_done), 16'd0);
      if (i == 2) mem_rd_ack = 1;
      step();
    end
    mem_rd_ack = 0;
    chk("rd_done_pulse", 16'(rd_done), 16'd1);
    chk("rd_req_lo", 16'(mem_rd_req), 16'd0);
    chk("rd_busy_lo", 16'(rd_busy), 16'd0);
    step();
    chk("rd_done_once", 16'(rd_done), 16'd0);
    bus_oe = 1;
    #1 chk("bus_beef", bus, 16'hBEEF);
    bus_oe = 0;
    bus_drv = 16'h5A5A;
    bus_en = 1;
    #1 chk("bus_released", bus, 16'h5A5A);
    bus_en = 0;
    // byte read
    rd_start = 1;
    rd_byte = 1;
    step();
    rd_start = 0;
    rd_byte = 0;
    mem_rdata = 16'hABCD;
    mem_rd_ack = 1;
    step();
    chk("byte_done", 16'(rd_done), 16'd1);
    mem_rdata = 16'h1234;
    step();
    mem_rd_ack = 0;
    bus_oe = 1;
    #1 chk("byte_rdq", bus, 16'h00CD);
    bus_oe = 0;
    chk("stray_ack_idle", 16'(rd_busy), 16'd0);
    // read-after-write: drain before request
    mem_wr_ready = 0;
    push(16'hA001);
    push(16'hA002);
    rd_start = 1;
    step();
    rd_start = 0;
    chk("drain_busy", 16'(rd_busy), 16'd1);
    chk("drain_noreq", 16'(mem_rd_req), 16'd0);
    step();
    chk("drain_hold_req", 16'(mem_rd_req), 16'd0);
    chk("drain_hold_data", mem_wdata, 16'hA001);
    mem_wr_ready = 1;
    step();
    chk("drain_req1", 16'(mem_rd_req), 16'd0);
    chk("drain_data2", mem_wdata, 16'hA002);
    step();
    chk("drain_req2", 16'(mem_rd_req), 16'd0);
    chk("drain_empty2", 16'(wr_empty), 16'd1);
    step();
    chk("drain_to_req", 16'(mem_rd_req), 16'd1);
    mem_rdata = 16'h7777;
    mem_rd_ack = 1;
    step();
    mem_rd_ack = 0;
    chk("drain_rd_done", 16'(rd_done), 16'd1);
    // simultaneous push and pop at count 2
    mem_wr_ready = 0;
    push(16'hB001);
    push(16'hB002);
    mem_wr_ready = 1;
    push(16'hB003);
    chk("pp_head", mem_wdata, 16'hB002);
    chk("pp_full", 16'(wr_full), 16'd0);
    step();
    chk("pp_head2", mem_wdata, 16'hB003);
    chk("pp_notempty", 16'(wr_empty), 16'd0);
    step();
    chk("pp_empty", 16'(wr_empty), 16'd1);
    // reset during REQ with two queued writes
    rd_start = 1;
    step();
    rd_start = 0;
    push(16'hD001);
    push(16'hD002);
    chk("req_wvalid_forced", 16'(mem_wr_valid), 16'd0);
    chk("req_queued", 16'(wr_empty), 16'd0);
    chk("req_active", 16'(mem_rd_req), 16'd1);
    #2 reset = 1;
    #1;
    chk("ar_empty", 16'(wr_empty), 16'd1);
    chk("ar_req", 16'(mem_rd_req), 16'd0);
    chk("ar_wvalid", 16'(mem_wr_valid), 16'd0);
    chk("ar_busy", 16'(rd_busy), 16'd0);
    chk("ar_ovf", 16'(wr_overflow), 16'd0);
    chk("ar_done", 16'(rd_done), 16'd0);
    bus_oe = 1;
    #1 chk("ar_rdq", bus, 16'h0000);
    bus_oe = 0;
    step();
    reset = 0;
    mem_rd_ack = 1;
    step();
    mem_rd_ack = 0;
    chk("ar_no_done", 16'(rd_done), 16'd0);
    chk("ar_idle", 16'(rd_busy), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
